// File: rtl/frame_packer.sv
// Packs a 32x32 pixel raster into an 8x8 thresholded bitmap word,
// then holds it for a settle window before strobing sample.
module frame_packer #(
  parameter int PIX_W       = 8,
  parameter int THRESH      = 128,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sof,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [63:0]      img,
  output logic             img_valid,
  output logic             busy,
  output logic             sample
);

  localparam int SW = PIX_W + 4;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SW-1:0] LIM = SW'(THRESH * 16);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [4:0]    row, col;
  logic [SW-1:0] acc [8];
  logic [63:0]   shadow, shadow_upd;
  logic [HW-1:0] hcnt;

  logic          xfer, sof_beat, close, last, hit;
  logic [2:0]    blk;
  logic [5:0]    bit_idx;
  logic [SW-1:0] sum;

  assign pix_ready = (state != HOLD);
  assign busy      = (state != IDLE);
  assign sample    = (state == HOLD) && (hcnt == HLAST);

  always_comb begin
    xfer       = pix_valid & pix_ready;
    sof_beat   = xfer & pix_sof;
    blk        = col[4:2];
    bit_idx    = {row[4:2], col[4:2]};
    sum        = acc[blk] + SW'(pix_data);
    hit        = (sum >= LIM);
    close      = xfer && !pix_sof && (state == CAPTURE)
                 && (row[1:0] == 2'd3) && (col[1:0] == 2'd3);
    last       = close && (row == 5'd31) && (col == 5'd31);
    shadow_upd = shadow;
    shadow_upd[bit_idx] = hit;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sof_beat) state_nx = CAPTURE;
      CAPTURE: if (last) state_nx = HOLD;
      HOLD:    if (hcnt == HLAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      shadow    <= '0;
      img       <= '0;
      img_valid <= 1'b0;
      hcnt      <= '0;
      for (int i = 0; i < 8; i++) acc[i] <= '0;
    end else begin
      img_valid <= 1'b0;
      if (state == HOLD) begin
        hcnt <= hcnt + 1'b1;
      end else if (sof_beat) begin
        // Any start-of-frame beat is pixel (0,0) of a fresh frame.
        for (int i = 0; i < 8; i++) acc[i] <= '0;
        acc[0] <= SW'(pix_data);
        shadow <= '0;
        row    <= '0;
        col    <= 5'd1;
      end else if (xfer && state == CAPTURE) begin
        if (close) begin
          acc[blk] <= '0;
          shadow   <= shadow_upd;
        end else begin
          acc[blk] <= sum;
        end
        if (last) begin
          img       <= shadow_upd;
          img_valid <= 1'b1;
          shadow    <= '0;
          row       <= '0;
          col       <= '0;
          hcnt      <= '0;
        end else begin
          col <= col + 5'd1;
          if (col == 5'd31) row <= row + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Randomized bench for frame_packer against a block-average model
// computed directly from whole frames.
module tb_frame_packer;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [63:0] img;
  logic        img_valid;
  logic        busy;
  logic        sample;

  frame_packer #(.PIX_W(8), .THRESH(128), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .img(img),
    .img_valid(img_valid), .busy(busy), .sample(sample)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot = 0;
  int cyc = 0;
  int vcyc = -100;
  int nvalid = 0;
  int nsample = 0;
  logic [63:0] exp_img = '0;
  int frame [1024];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && img_valid) begin
      nvalid++;
      vcyc = cyc;
      chk("img", img, exp_img);
      chk("hold_ready", 64'(pix_ready), 64'd0);
    end
    if (!rst && sample) begin
      nsample++;
      chk("smp_lat", 64'(cyc - vcyc), 64'(HOLD - 1));
      chk("smp_img", img, exp_img);
    end
  end

  function automatic logic [63:0] model_img();
    logic [63:0] r = '0;
    for (int br = 0; br < 8; br++)
      for (int bc = 0; bc < 8; bc++) begin
        int s = 0;
        for (int y = 0; y < 4; y++)
          for (int x = 0; x < 4; x++)
            s += frame[(br*4+y)*32 + bc*4+x];
        r[br*8+bc] = (s >= 128*16);
      end
    return r;
  endfunction

  task automatic send(input int d, input logic s);
    int n = 0;
    @(negedge clk);
    pix_data = 8'(d); pix_sof = s; pix_valid = 1'b1;
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_to", 64'd0, 64'd1);
    @(posedge clk);
    #1 pix_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < 1024; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof = 1'($urandom);
        pix_data = 8'($urandom);
      end
      send(frame[i], i == 0);
    end
  endtask

  task automatic wait_done();
    int n0 = nsample;
    int k = 0;
    while (nsample == n0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (nsample == n0) chk("sample_to", 64'd0, 64'd1);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic run(input string tag, input bit gaps,
                     input logic [63:0] lit);
    int v0;
    exp_img = model_img();
    chk({tag, "_model"}, exp_img, lit);
    v0 = nvalid;
    send_frame(gaps);
    wait_done();
    chk({tag, "_pulses"}, 64'(nvalid), 64'(v0 + 1));
  endtask

  task automatic fill_block(input int br, input int bc, input int v);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        frame[(br*4+y)*32 + bc*4+x] = v;
  endtask

  initial begin
    int v0;
    logic [63:0] rnd;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_img", img, 64'd0);
    chk("rst_valid", 64'(img_valid), 64'd0);
    chk("rst_sample", 64'(sample), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(pix_ready), 64'd1);

    foreach (frame[i]) frame[i] = 255;
    run("ones", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    foreach (frame[i]) frame[i] = 0;
    run("zeros", 1'b0, 64'h0);
    fill_block(0, 0, 128);
    run("b00_128", 1'b0, 64'h1);
    fill_block(0, 0, 127);
    run("b00_127", 1'b0, 64'h0);
    foreach (frame[i]) frame[i] = 0;
    fill_block(7, 7, 255);
    run("b77", 1'b0, 64'h8000_0000_0000_0000);
    run("b77_gap", 1'b1, 64'h8000_0000_0000_0000);

    for (int f = 0; f < 2; f++) begin
      foreach (frame[i]) frame[i] = $urandom_range(96, 160);
      rnd = model_img();
      run("rand", 1'b1, rnd);
    end

    // Junk before sof, an aborted frame, then a full one.
    foreach (frame[i]) frame[i] = 255;
    exp_img = model_img();
    v0 = nvalid;
    for (int i = 0; i < 20; i++) send($urandom_range(0, 255), 1'b0);
    send($urandom_range(0, 255), 1'b1);
    for (int i = 0; i < 499; i++) send($urandom_range(0, 255), 1'b0);
    send_frame(1'b0);
    wait_done();
    chk("restart_pulses", 64'(nvalid), 64'(v0 + 1));

    // Reset mid-frame after a completed frame.
    for (int i = 0; i < 300; i++) send(frame[i], i == 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_img", img, 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ready", 64'(pix_ready), 64'd1);
    for (int br = 0; br < 8; br++)
      for (int bc = 0; bc < 8; bc++)
        fill_block(br, bc, ((br + bc) % 2 == 0) ? 200 : 30);
    run("checker", 1'b1, 64'hAA55_AA55_AA55_AA55);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
